// File: rtl/lzw_segment_reverse.sv
// lzw_segment_reverse: buffers descriptor-framed segments in a two-bank
// ping-pong store and replays each one in original or reversed beat order.
// One bank fills while the other drains, so steady-state throughput is one
// beat per cycle once a segment has been fully buffered.
module lzw_segment_reverse #(
  parameter int DATA_W  = 8,
  parameter int MAX_SEG = 32,
  parameter int LEN_W   = 6,
  parameter int CNT_W   = 16
) (
  input  logic              I_sys_clk,
  input  logic              I_sys_rst_n,
  input  logic              I_state_clr,
  input  logic [LEN_W-1:0]  I_seg_len,
  input  logic              I_seg_rev,
  input  logic              I_seg_valid,
  output logic              O_seg_ready,
  input  logic [DATA_W-1:0] I_data,
  input  logic              I_data_valid,
  output logic              O_data_ready,
  output logic [DATA_W-1:0] O_data,
  output logic              O_data_valid,
  output logic              O_data_last,
  input  logic              I_data_ready,
  output logic [CNT_W-1:0]  O_seg_cnt,
  output logic [CNT_W-1:0]  O_err_cnt
);

  localparam int               AW      = $clog2(MAX_SEG);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_SEG);
  localparam logic [CNT_W-1:0] CNT_TOP = '1;

  typedef enum logic {W_IDLE, W_FILL} w_state_t;
  typedef enum logic {R_IDLE, R_DRAIN} r_state_t;

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_TOP) ? cnt : cnt + 1'b1;
  endfunction

  // First read address of a bank: top of the segment when reversing.
  function automatic logic [AW-1:0] start_idx(input logic [LEN_W-1:0] len,
                                              input logic             rev);
    return rev ? AW'(len - 1'b1) : '0;
  endfunction

  // Read address walk; wraps modulo the bank depth.
  function automatic logic [AW-1:0] step_idx(input logic [AW-1:0] idx,
                                             input logic          rev);
    return rev ? idx - 1'b1 : idx + 1'b1;
  endfunction

  // Storage: bank index is the MSB of the address.
  logic [DATA_W-1:0] mem [2*MAX_SEG];
  logic [LEN_W-1:0]  bank_len [2];
  logic [1:0]        bank_rev;
  logic [1:0]        full, full_nxt;
  logic              wr_bank, rd_bank, nxt_bank;

  // Write side
  w_state_t          w_state, w_state_nxt;
  logic [AW-1:0]     w_addr, w_last;
  logic [LEN_W-1:0]  w_len;
  logic              w_rev;
  logic              desc_acc, beat_acc, fill_done;
  logic              len_zero, len_over, desc_err;
  logic [LEN_W-1:0]  len_clamp;

  // Read side
  r_state_t          r_state, r_state_nxt;
  logic [AW-1:0]     rd_idx, nxt_start;
  logic [LEN_W-1:0]  rd_left;
  logic              rd_rev;
  logic              hs, last_hs, chain, issue, start_rd;

  assign len_zero  = (I_seg_len == '0);
  assign len_over  = (I_seg_len > MAX_LEN);
  assign len_clamp = len_over ? MAX_LEN : I_seg_len;
  assign desc_err  = desc_acc && (len_zero || len_over);

  assign O_seg_ready  = I_sys_rst_n && (w_state == W_IDLE) && !full[wr_bank];
  assign O_data_ready = I_sys_rst_n && (w_state == W_FILL);
  assign desc_acc     = I_seg_valid && O_seg_ready;
  assign beat_acc     = I_data_valid && O_data_ready;
  assign fill_done    = beat_acc && (w_addr == w_last);

  assign hs        = O_data_valid && I_data_ready;
  assign last_hs   = hs && O_data_last;
  assign nxt_bank  = ~rd_bank;
  assign chain     = last_hs && full[nxt_bank];
  assign issue     = (r_state == R_DRAIN) && (rd_left != '0) &&
                     (!O_data_valid || I_data_ready);
  assign start_rd  = (r_state == R_IDLE) && full[rd_bank];
  assign nxt_start = start_idx(bank_len[nxt_bank], bank_rev[nxt_bank]);

  // Write FSM state register.
  always_ff @(posedge I_sys_clk) begin
    if (!I_sys_rst_n) w_state <= W_IDLE;
    else              w_state <= w_state_nxt;
  end

  // Write FSM next state: zero-length descriptors are consumed without a fill.
  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (desc_acc && !len_zero) w_state_nxt = W_FILL;
      W_FILL:  if (fill_done) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Latch the (clamped) descriptor and advance the fill address per beat.
  always_ff @(posedge I_sys_clk) begin
    if (desc_acc) begin
      w_len  <= len_clamp;
      w_rev  <= I_seg_rev;
      w_last <= AW'(len_clamp - 1'b1);
      w_addr <= '0;
    end else if (beat_acc) begin
      w_addr <= w_addr + 1'b1;
    end
  end

  // Beat storage write port.
  always_ff @(posedge I_sys_clk) begin
    if (beat_acc) mem[{wr_bank, w_addr}] <= I_data;
  end

  // Bank occupancy: set and clear can hit different banks in the same cycle.
  always_comb begin
    full_nxt = full;
    if (last_hs)   full_nxt[rd_bank] = 1'b0;
    if (fill_done) full_nxt[wr_bank] = 1'b1;
  end

  // Bank flags and ping-pong pointers.
  always_ff @(posedge I_sys_clk) begin
    if (!I_sys_rst_n) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      full <= full_nxt;
      if (fill_done) wr_bank <= ~wr_bank;
      if (last_hs)   rd_bank <= ~rd_bank;
    end
  end

  // Segment metadata recorded when a bank completes.
  always_ff @(posedge I_sys_clk) begin
    if (fill_done) begin
      bank_len[wr_bank] <= w_len;
      bank_rev[wr_bank] <= w_rev;
    end
  end

  // Read FSM state register.
  always_ff @(posedge I_sys_clk) begin
    if (!I_sys_rst_n) r_state <= R_IDLE;
    else              r_state <= r_state_nxt;
  end

  // Read FSM next state: stay draining when the other bank is already full.
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (full[rd_bank]) r_state_nxt = R_DRAIN;
      R_DRAIN: if (last_hs && !chain) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read index and remaining-beat count; a chained bank skips its first beat
  // because that beat goes straight into the output register.
  always_ff @(posedge I_sys_clk) begin
    if (start_rd) begin
      rd_idx  <= start_idx(bank_len[rd_bank], bank_rev[rd_bank]);
      rd_left <= bank_len[rd_bank];
      rd_rev  <= bank_rev[rd_bank];
    end else if (chain) begin
      rd_idx  <= step_idx(nxt_start, bank_rev[nxt_bank]);
      rd_left <= bank_len[nxt_bank] - 1'b1;
      rd_rev  <= bank_rev[nxt_bank];
    end else if (issue) begin
      rd_idx  <= step_idx(rd_idx, rd_rev);
      rd_left <= rd_left - 1'b1;
    end
  end

  // Output register: holds while stalled, refills on handshake or when empty.
  always_ff @(posedge I_sys_clk) begin
    if (!I_sys_rst_n) begin
      O_data       <= '0;
      O_data_valid <= 1'b0;
      O_data_last  <= 1'b0;
    end else if (chain) begin
      O_data       <= mem[{nxt_bank, nxt_start}];
      O_data_valid <= 1'b1;
      O_data_last  <= (bank_len[nxt_bank] == LEN_W'(1));
    end else if (last_hs) begin
      O_data_valid <= 1'b0;
      O_data_last  <= 1'b0;
    end else if (issue) begin
      O_data       <= mem[{rd_bank, rd_idx}];
      O_data_valid <= 1'b1;
      O_data_last  <= (rd_left == LEN_W'(1));
    end
  end

  // Statistics: clear has priority over a coincident increment.
  always_ff @(posedge I_sys_clk) begin
    if (!I_sys_rst_n || I_state_clr) begin
      O_seg_cnt <= '0;
      O_err_cnt <= '0;
    end else begin
      if (last_hs)  O_seg_cnt <= sat_inc(O_seg_cnt);
      if (desc_err) O_err_cnt <= sat_inc(O_err_cnt);
    end
  end

endmodule

// File: tb/tb_lzw_segment_reverse.sv
// Randomised bench for lzw_segment_reverse with a queue-based scoreboard.
module tb_lzw_segment_reverse;

  localparam int MAX_SEG = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_TOP = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       state_clr = 1'b0;
  logic [5:0] seg_len = '0;
  logic       seg_rev = 1'b0;
  logic       seg_valid = 1'b0;
  logic       seg_ready;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_last;
  logic       dout_ready = 1'b1;
  logic [CNT_W-1:0] seg_cnt;
  logic [CNT_W-1:0] err_cnt;

  lzw_segment_reverse #(
    .DATA_W(8), .MAX_SEG(MAX_SEG), .LEN_W(6), .CNT_W(CNT_W)
  ) dut (
    .I_sys_clk(clk), .I_sys_rst_n(rst_n), .I_state_clr(state_clr),
    .I_seg_len(seg_len), .I_seg_rev(seg_rev), .I_seg_valid(seg_valid),
    .O_seg_ready(seg_ready),
    .I_data(din), .I_data_valid(din_valid), .O_data_ready(din_ready),
    .O_data(dout), .O_data_valid(dout_valid), .O_data_last(dout_last),
    .I_data_ready(dout_ready),
    .O_seg_cnt(seg_cnt), .O_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  int seg_m    = 0;
  int err_m    = 0;

  logic [7:0] stim_q[$];
  logic [7:0] exp_d[$];
  bit         exp_l[$];
  logic [7:0] out_log[$];
  bit         last_log[$];
  int         hs_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc++;

  // Downstream ready generator.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = 1'($urandom_range(1));
      default: dout_ready = 1'b0;
    endcase
  end

  // Output monitor: scoreboard, hold-while-stalled, segment counter model.
  logic [7:0] prev_d;
  bit         prev_l;
  bit         prev_hold = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_d.delete();
      exp_l.delete();
      seg_m     = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(dout_valid), 32'd1);
        chk("hold_data", 32'(dout), 32'(prev_d));
        chk("hold_last", 32'(dout_last), 32'(prev_l));
      end
      if (dout_valid && dout_ready) begin
        if (exp_d.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got %0h with empty scoreboard (cycle %0d)", dout, cyc);
        end else begin
          logic [7:0] ed;
          bit         el;
          ed = exp_d.pop_front();
          el = exp_l.pop_front();
          chk("out_data", 32'(dout), 32'(ed));
          chk("out_last", 32'(dout_last), 32'(el));
        end
        out_log.push_back(dout);
        last_log.push_back(dout_last);
        hs_cyc.push_back(cyc);
      end
      if (state_clr) seg_m = 0;
      else if (dout_valid && dout_ready && dout_last)
        seg_m = (seg_m == CNT_TOP) ? CNT_TOP : seg_m + 1;
      prev_hold = dout_valid && !dout_ready;
      prev_d    = dout;
      prev_l    = dout_last;
    end
  end

  // Sends one descriptor and nsend beats (all of the clamped length if < 0)
  // from stim_q; records the expected output segment at descriptor accept.
  task automatic send_seg(input int len, input bit rev, input int nsend, input int gap_pct);
    int eff;
    int n;
    bit ok;
    eff = (len > MAX_SEG) ? MAX_SEG : len;
    n   = (nsend < 0) ? eff : nsend;
    seg_len   = 6'(len);
    seg_rev   = rev;
    seg_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge clk);
      ok = seg_ready;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL desc_timeout: seg_ready stayed %0b, expected 1", seg_ready);
      seg_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    seg_valid = 1'b0;
    if (len == 0 || len > MAX_SEG) err_m = (err_m == CNT_TOP) ? CNT_TOP : err_m + 1;
    for (int i = 0; i < eff; i++) begin
      exp_d.push_back(stim_q[rev ? eff - 1 - i : i]);
      exp_l.push_back(i == eff - 1);
    end
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) < 32'(gap_pct)) begin
        @(posedge clk); #1;
      end
      din       = stim_q[i];
      din_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 1000 && !ok; t++) begin
        @(negedge clk);
        ok = din_ready;
      end
      if (!ok) begin
        n_checks++;
        $display("FAIL beat_timeout: data_ready stayed %0b, expected 1", din_ready);
        din_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      din_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_d.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (exp_d.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d beats pending, expected 0", exp_d.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fill_rand(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg_ready", 32'(seg_ready), 0);
    chk("rst_data_ready", 32'(din_ready), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_last", 32'(dout_last), 0);
    chk("rst_data", 32'(dout), 0);
    chk("rst_seg_cnt", 32'(seg_cnt), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_seg_ready", 32'(seg_ready), 1);

    // Reverse of four beats, with latency
    out_log.delete(); last_log.delete();
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_seg(4, 1'b1, -1, 0);
    chk("lat_k0_valid", 32'(dout_valid), 0);
    @(posedge clk); #1;
    chk("lat_k1_valid", 32'(dout_valid), 0);
    @(posedge clk); #1;
    chk("lat_k2_valid", 32'(dout_valid), 1);
    chk("lat_k2_data", 32'(dout), 32'h44);
    wait_drain();
    chk("t1_count", 32'(out_log.size()), 4);
    if (out_log.size() == 4) begin
      chk("t1_b0", 32'(out_log[0]), 32'h44);
      chk("t1_b1", 32'(out_log[1]), 32'h33);
      chk("t1_b2", 32'(out_log[2]), 32'h22);
      chk("t1_b3", 32'(out_log[3]), 32'h11);
      chk("t1_last", 32'(last_log[3]), 1);
      chk("t1_not_last", 32'(last_log[2]), 0);
    end
    chk("t1_seg_cnt", 32'(seg_cnt), 1);
    chk("t1_seg_model", 32'(seg_cnt), 32'(seg_m));

    // Pass segment then full-size reversed segment, continuous traffic
    out_log.delete(); last_log.delete(); hs_cyc.delete();
    stim_q = '{8'hA1, 8'hB2, 8'hC3};
    send_seg(3, 1'b0, -1, 0);
    stim_q.delete();
    for (int i = 0; i < 32; i++) stim_q.push_back(8'(i));
    send_seg(32, 1'b1, -1, 0);
    wait_drain();
    chk("t2_count", 32'(out_log.size()), 35);
    if (out_log.size() == 35) begin
      chk("t2_first", 32'(out_log[0]), 32'hA1);
      chk("t2_third", 32'(out_log[2]), 32'hC3);
      chk("t2_rev_first", 32'(out_log[3]), 32'd31);
      chk("t2_rev_end", 32'(out_log[34]), 32'd0);
      chk("t2_no_bubble", 32'(hs_cyc[34] - hs_cyc[3]), 32'd31);
    end
    chk("t2_seg_cnt", 32'(seg_cnt), 3);

    // Both banks full, then back-to-back drain without a bubble
    rdy_mode = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    fill_rand(2);
    send_seg(2, 1'b1, -1, 0);
    fill_rand(3);
    send_seg(3, 1'b0, -1, 0);
    @(posedge clk); #1;
    chk("both_full_seg_ready", 32'(seg_ready), 0);
    chk("both_full_data_ready", 32'(din_ready), 0);
    out_log.delete(); last_log.delete(); hs_cyc.delete();
    rdy_mode = 0;
    wait_drain();
    chk("b2b_count", 32'(hs_cyc.size()), 5);
    if (hs_cyc.size() == 5) chk("b2b_no_bubble", 32'(hs_cyc[4] - hs_cyc[0]), 32'd4);

    // Illegal descriptors: zero length, then over-length clamped to MAX_SEG
    out_log.delete(); last_log.delete();
    stim_q.delete();
    send_seg(0, 1'b0, -1, 0);
    fill_rand(40);
    send_seg(40, 1'b1, -1, 0);
    wait_drain();
    chk("err_cnt_lit", 32'(err_cnt), 2);
    chk("err_cnt_model", 32'(err_cnt), 32'(err_m));
    chk("clamp_count", 32'(out_log.size()), 32);

    // Random segments with random downstream stalls
    rdy_mode = 1;
    for (int s = 0; s < 12; s++) begin
      int  len;
      bit  rev;
      len = int'($urandom_range(1, MAX_SEG));
      rev = 1'($urandom_range(1));
      fill_rand(len);
      send_seg(len, rev, -1, 20);
    end
    wait_drain();
    rdy_mode = 0;
    wait_drain();
    chk("rand_seg_cnt", 32'(seg_cnt), 32'(seg_m));
    chk("rand_err_cnt", 32'(err_cnt), 32'(err_m));

    // Reset in the middle of a segment
    fill_rand(5);
    send_seg(5, 1'b1, 2, 0);
    rst_n = 1'b0;
    err_m = 0;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(dout_valid), 0);
    chk("mid_rst_data", 32'(dout), 0);
    chk("mid_rst_last", 32'(dout_last), 0);
    chk("mid_rst_seg_ready", 32'(seg_ready), 0);
    chk("mid_rst_data_ready", 32'(din_ready), 0);
    chk("mid_rst_seg_cnt", 32'(seg_cnt), 0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_log.delete(); last_log.delete();
    fill_rand(2);
    send_seg(2, 1'b0, -1, 0);
    wait_drain();
    chk("post_rst_count", 32'(out_log.size()), 2);
    chk("post_rst_seg_cnt", 32'(seg_cnt), 1);

    // Clear pulse coincident with the last-beat handshake
    rdy_mode = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    fill_rand(1);
    send_seg(1, 1'b0, -1, 0);
    begin
      int t;
      t = 0;
      while (!dout_valid && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      if (!dout_valid) begin
        n_checks++;
        $display("FAIL clr_wait: valid %0b, expected 1", dout_valid);
      end
    end
    #1;
    rdy_mode = 0;
    @(posedge clk); #2;
    state_clr = 1'b1;
    err_m = 0;
    @(posedge clk); #2;
    state_clr = 1'b0;
    chk("clr_seg_cnt", 32'(seg_cnt), 0);
    chk("clr_seg_model", 32'(seg_cnt), 32'(seg_m));
    chk("clr_err_cnt", 32'(err_cnt), 0);
    wait_drain();

    // Saturation of the segment counter
    for (int s = 0; s < 17; s++) begin
      fill_rand(1);
      send_seg(1, 1'b1, -1, 0);
    end
    wait_drain();
    chk("sat_seg_cnt", 32'(seg_cnt), 32'd15);
    chk("sat_seg_model", 32'(seg_cnt), 32'(seg_m));

    chk("scoreboard_empty", 32'(exp_d.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
